// File: rtl/window_gen_3x3_if.sv
// Stream-side bundle of the 3x3 window generator: byte input handshake plus window/tag output.
// slave is the generator's view, master is the producer/consumer around it.
interface window_gen_3x3_if #(
  parameter int WIDTH  = 350,
  parameter int HEIGHT = 350
);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [71:0]   window;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic [1:0]    out_ch;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, window, out_row, out_col, out_ch
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, window, out_row, out_col, out_ch
  );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 same-channel window generator over a channel-interleaved raster stream, zero-padded at the borders.
// Window registered on the byte LAG positions after its centre, out_valid one cycle later; in_valid gaps stall the pipe.
module window_gen_3x3 #(
  parameter int WIDTH    = 350,
  parameter int HEIGHT   = 350,
  parameter int CHANNELS = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           frame_done,
  window_gen_3x3_if.slave bus
);
  localparam int L   = WIDTH * CHANNELS;
  localparam int N   = L * HEIGHT;
  localparam int LAG = L + CHANNELS;
  localparam int TOT = N + LAG;
  localparam int IW  = $clog2(TOT + 1);
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SL  = 2 * CHANNELS;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          advance;
  logic          emit;
  logic [7:0]    din;

  logic [7:0]    line0 [L];
  logic [7:0]    line1 [L];
  logic [PW-1:0] ptr;
  logic [7:0]    d1;
  logic [7:0]    d2;

  logic [7:0]    ch_top [SL];
  logic [7:0]    ch_mid [SL];
  logic [7:0]    ch_bot [SL];
  logic [7:0]    nxt_top [SL+1];
  logic [7:0]    nxt_mid [SL+1];
  logic [7:0]    nxt_bot [SL+1];

  logic [1:0]    cen_ch;
  logic [CW-1:0] cen_col;
  logic [RW-1:0] cen_row;
  logic          top_ok;
  logic          bot_ok;
  logic          left_ok;
  logic          right_ok;
  logic [71:0]   win_nxt;

  logic          out_valid_q;
  logic [71:0]   window_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [1:0]    ch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (bus.in_valid && idx == IW'(N - 1)) state_nxt = FLUSH;
      FLUSH:   if (idx == IW'(TOT - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = (state == STREAM);
  assign frame_done   = (state == DONE);
  assign advance      = (state == STREAM && bus.in_valid) || (state == FLUSH);
  assign din          = (state == STREAM) ? bus.in_data : 8'd0;
  // idx counts accepted plus injected bytes, so the window for centre k-LAG exists once idx reaches LAG
  assign emit         = advance && (idx >= IW'(LAG));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      ptr <= '0;
    end else begin
      if (state == DONE) begin
        idx <= '0;
      end else if (advance) begin
        idx <= idx + IW'(1);
      end
      if (advance) begin
        ptr <= (ptr == PW'(L - 1)) ? '0 : ptr + PW'(1);
      end
    end
  end

  // Two cascaded row delays; stale contents at frame start only reach masked taps
  assign d1 = line0[ptr];
  assign d2 = line1[ptr];

  always_ff @(posedge clk) begin
    if (advance) begin
      line0[ptr] <= din;
      line1[ptr] <= d1;
    end
  end

  // Stage 0 of each chain is its live input, so taps see the byte arriving this cycle
  always_comb begin
    nxt_bot[0] = din;
    nxt_mid[0] = d1;
    nxt_top[0] = d2;
    for (int s = 1; s <= SL; s++) begin
      nxt_bot[s] = ch_bot[s-1];
      nxt_mid[s] = ch_mid[s-1];
      nxt_top[s] = ch_top[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SL; s++) begin
        ch_bot[s] <= '0;
        ch_mid[s] <= '0;
        ch_top[s] <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < SL; s++) begin
        ch_bot[s] <= nxt_bot[s];
        ch_mid[s] <= nxt_mid[s];
        ch_top[s] <= nxt_top[s];
      end
    end
  end

  assign top_ok   = (cen_row != '0);
  assign bot_ok   = (cen_row != RW'(HEIGHT - 1));
  assign left_ok  = (cen_col != '0);
  assign right_ok = (cen_col != CW'(WIDTH - 1));

  // Oldest chain stage is the left column; border masks also hide row wrap inside the chains
  always_comb begin
    win_nxt        = '0;
    win_nxt[0+:8]  = (top_ok && left_ok)  ? nxt_top[SL]       : 8'd0;
    win_nxt[8+:8]  = top_ok               ? nxt_top[CHANNELS] : 8'd0;
    win_nxt[16+:8] = (top_ok && right_ok) ? nxt_top[0]        : 8'd0;
    win_nxt[24+:8] = left_ok              ? nxt_mid[SL]       : 8'd0;
    win_nxt[32+:8] = nxt_mid[CHANNELS];
    win_nxt[40+:8] = right_ok             ? nxt_mid[0]        : 8'd0;
    win_nxt[48+:8] = (bot_ok && left_ok)  ? nxt_bot[SL]       : 8'd0;
    win_nxt[56+:8] = bot_ok               ? nxt_bot[CHANNELS] : 8'd0;
    win_nxt[64+:8] = (bot_ok && right_ok) ? nxt_bot[0]        : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cen_ch  <= '0;
      cen_col <= '0;
      cen_row <= '0;
    end else if (emit) begin
      if (cen_ch == 2'(CHANNELS - 1)) begin
        cen_ch <= '0;
        if (cen_col == CW'(WIDTH - 1)) begin
          cen_col <= '0;
          cen_row <= (cen_row == RW'(HEIGHT - 1)) ? '0 : cen_row + RW'(1);
        end else begin
          cen_col <= cen_col + CW'(1);
        end
      end else begin
        cen_ch <= cen_ch + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      window_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ch_q        <= '0;
    end else begin
      out_valid_q <= emit;
      if (emit) begin
        window_q <= win_nxt;
        row_q    <= cen_row;
        col_q    <= cen_col;
        ch_q     <= cen_ch;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.window    = window_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench: a 4x3x1 instance and a 3x2x3 instance of the window generator, checked against
// hand-computed windows and a zero-padded neighbourhood model of the same small images.
module tb_window_gen_3x3;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, start1, start3, done1, done3;

  window_gen_3x3_if #(.WIDTH(4), .HEIGHT(3)) if1 ();
  window_gen_3x3_if #(.WIDTH(3), .HEIGHT(2)) if3 ();

  window_gen_3x3 #(.WIDTH(4), .HEIGHT(3), .CHANNELS(1)) u1 (
    .clk(clk), .reset(rst1), .start(start1), .frame_done(done1), .bus(if1.slave)
  );
  window_gen_3x3 #(.WIDTH(3), .HEIGHT(2), .CHANNELS(3)) u3 (
    .clk(clk), .reset(rst3), .start(start3), .frame_done(done3), .bus(if3.slave)
  );

  typedef struct {
    logic [71:0] w;
    int          r;
    int          c;
    int          ch;
  } obs_t;

  obs_t q1[$];
  obs_t q3[$];
  int   acc1, first_acc1, stall_ov1, done_cnt1, done_cnt3;
  bit   stall_prev1;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [71:0] W1_00 = 72'h06_05_00_02_01_00_00_00_00;
  localparam logic [71:0] W1_11 = 72'h0B_0A_09_07_06_05_03_02_01;
  localparam logic [71:0] W1_23 = 72'h00_00_00_00_0C_0B_00_08_07;
  localparam logic [71:0] W3_5  = 72'h52_42_32_22_12_02_00_00_00;

  always @(negedge clk) begin
    obs_t o;
    if (if1.out_valid === 1'b1) begin
      o.w = if1.window; o.r = int'(if1.out_row); o.c = int'(if1.out_col); o.ch = int'(if1.out_ch);
      q1.push_back(o);
      if (q1.size() == 1) first_acc1 = acc1;
      if (stall_prev1) stall_ov1++;
    end
    if (if1.in_valid === 1'b1 && if1.in_ready === 1'b1) acc1++;
    stall_prev1 = (if1.in_ready === 1'b1) && (if1.in_valid === 1'b0);
    if (done1 === 1'b1) done_cnt1++;
    if (if3.out_valid === 1'b1) begin
      o.w = if3.window; o.r = int'(if3.out_row); o.c = int'(if3.out_col); o.ch = int'(if3.out_ch);
      q3.push_back(o);
    end
    if (done3 === 1'b1) done_cnt3++;
  end

  function automatic int pixval(input bit multi, input int i);
    return multi ? (16 * (i / 3) + i % 3) : (i + 1);
  endfunction

  function automatic logic [71:0] exp_win(input bit multi, input int w, input int h, input int c,
                                          input int r, input int col, input int ch);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int rr, cc;
        rr = r + i - 1;
        cc = col + j - 1;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          v[8*(3*i+j) +: 8] = 8'(pixval(multi, (rr * w + cc) * c + ch));
      end
    return v;
  endfunction

  task automatic clear1();
    q1.delete(); acc1 = 0; first_acc1 = -1; stall_ov1 = 0; done_cnt1 = 0; stall_prev1 = 0;
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic send1(input bit gap, input bit poke, input bit tail);
    for (int i = 0; i < 12; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 8'(pixval(0, i));
      start1 = poke && (i == 3);
      @(posedge clk); #1;
      start1 = 1'b0;
      if (gap && i != 11) begin
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    if1.in_valid = tail;
    if1.in_data  = tail ? 8'hEE : 8'h00;
  endtask

  task automatic wait_done(input bit sel, output int flush, output bit got);
    flush = 0; got = 0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if ((sel ? done3 : done1) === 1'b1) got = 1; else flush++;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if3.in_valid = 1'b0; if3.in_data = '0;
    clear1();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (if1.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", if1.in_ready); end
    vectors++; if (if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", if1.out_valid); end
    vectors++; if (if1.window !== 72'h0) begin miscompares++; $display("FAIL reset_window got %h want 0", if1.window); end
    vectors++; if ({if1.out_row, if1.out_col, if1.out_ch} !== 6'h0) begin miscompares++; $display("FAIL reset_tags got %h want 0", {if1.out_row, if1.out_col, if1.out_ch}); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", done1); end
    vectors++; if (if3.out_valid !== 1'b0 || if3.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_u3 got %b%b want 00", if3.out_valid, if3.in_ready); end
    rst1 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    vectors++; if (if1.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready got %b want 0", if1.in_ready); end
  endtask

  task automatic test_basic();
    int flush; bit got;
    clear1();
    pulse_start(0);
    send1(0, 0, 0);
    wait_done(0, flush, got);
    @(posedge clk); #1;
    vectors++; if (!got) begin miscompares++; $display("FAIL basic_done_timeout got none want frame_done"); end
    vectors++; if (flush != 5) begin miscompares++; $display("FAIL basic_flush got %0d want 5", flush); end
    vectors++; if (done_cnt1 != 1) begin miscompares++; $display("FAIL basic_done_count got %0d want 1", done_cnt1); end
    vectors++; if (q1.size() != 12) begin miscompares++; $display("FAIL basic_count got %0d want 12", q1.size()); end
    vectors++; if (first_acc1 != 6) begin miscompares++; $display("FAIL basic_first_latency got %0d want 6", first_acc1); end
    vectors++; if (q1[0].w !== W1_00) begin miscompares++; $display("FAIL basic_win00 got %h want %h", q1[0].w, W1_00); end
    vectors++; if (q1[5].w !== W1_11) begin miscompares++; $display("FAIL basic_win11 got %h want %h", q1[5].w, W1_11); end
    vectors++; if (q1[11].w !== W1_23) begin miscompares++; $display("FAIL basic_win23 got %h want %h", q1[11].w, W1_23); end
    for (int i = 0; i < q1.size(); i++) begin
      logic [71:0] e;
      e = exp_win(0, 4, 3, 1, i / 4, i % 4, 0);
      vectors++; if (q1[i].w !== e) begin miscompares++; $display("FAIL basic_win[%0d] got %h want %h", i, q1[i].w, e); end
      vectors++; if (q1[i].r != i / 4 || q1[i].c != i % 4 || q1[i].ch != 0) begin miscompares++; $display("FAIL basic_tag[%0d] got %0d/%0d/%0d want %0d/%0d/0", i, q1[i].r, q1[i].c, q1[i].ch, i / 4, i % 4); end
    end
  endtask

  task automatic test_stall();
    int flush; bit got;
    clear1();
    pulse_start(0);
    send1(1, 0, 0);
    wait_done(0, flush, got);
    @(posedge clk); #1;
    vectors++; if (!got || flush != 5) begin miscompares++; $display("FAIL stall_flush got %0d/%0d want 1/5", got, flush); end
    vectors++; if (q1.size() != 12) begin miscompares++; $display("FAIL stall_count got %0d want 12", q1.size()); end
    vectors++; if (stall_ov1 != 0) begin miscompares++; $display("FAIL stall_out_valid got %0d want 0", stall_ov1); end
    vectors++; if (first_acc1 != 6) begin miscompares++; $display("FAIL stall_first_latency got %0d want 6", first_acc1); end
    for (int i = 0; i < q1.size(); i++) begin
      logic [71:0] e;
      e = exp_win(0, 4, 3, 1, i / 4, i % 4, 0);
      vectors++; if (q1[i].w !== e || q1[i].r != i / 4 || q1[i].c != i % 4) begin miscompares++; $display("FAIL stall_win[%0d] got %h @%0d,%0d want %h", i, q1[i].w, q1[i].r, q1[i].c, e); end
    end
  endtask

  task automatic test_back_to_back();
    int flush; bit got;
    clear1();
    pulse_start(0);
    send1(0, 0, 0);
    wait_done(0, flush, got);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    vectors++; if (!got || if1.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done got %0d/%b want 1/0", got, if1.in_ready); end
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_start_in_idle got %b want 1", if1.in_ready); end
    send1(0, 0, 0);
    wait_done(0, flush, got);
    @(posedge clk); #1;
    vectors++; if (q1.size() != 24 || done_cnt1 != 2) begin miscompares++; $display("FAIL b2b_count got %0d/%0d want 24/2", q1.size(), done_cnt1); end
    vectors++; if (q1[12].w !== W1_00) begin miscompares++; $display("FAIL b2b_win00 got %h want %h", q1[12].w, W1_00); end
    vectors++; if (q1[17].w !== W1_11) begin miscompares++; $display("FAIL b2b_win11 got %h want %h", q1[17].w, W1_11); end
    vectors++; if (q1[23].w !== W1_23) begin miscompares++; $display("FAIL b2b_win23 got %h want %h", q1[23].w, W1_23); end
  endtask

  task automatic test_multichannel();
    int flush; bit got;
    q3.delete(); done_cnt3 = 0;
    pulse_start(1);
    for (int i = 0; i < 18; i++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 8'(pixval(1, i));
      @(posedge clk); #1;
    end
    if3.in_valid = 1'b0;
    wait_done(1, flush, got);
    @(posedge clk); #1;
    vectors++; if (!got || flush != 12) begin miscompares++; $display("FAIL mc_flush got %0d/%0d want 1/12", got, flush); end
    vectors++; if (q3.size() != 18 || done_cnt3 != 1) begin miscompares++; $display("FAIL mc_count got %0d/%0d want 18/1", q3.size(), done_cnt3); end
    vectors++; if (q3[5].w !== W3_5) begin miscompares++; $display("FAIL mc_win_r0c1ch2 got %h want %h", q3[5].w, W3_5); end
    for (int i = 0; i < q3.size(); i++) begin
      logic [71:0] e;
      e = exp_win(1, 3, 2, 3, i / 9, (i / 3) % 3, i % 3);
      vectors++; if (q3[i].w !== e) begin miscompares++; $display("FAIL mc_win[%0d] got %h want %h", i, q3[i].w, e); end
      vectors++; if (q3[i].r != i / 9 || q3[i].c != (i / 3) % 3 || q3[i].ch != i % 3) begin miscompares++; $display("FAIL mc_tag[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, q3[i].r, q3[i].c, q3[i].ch, i / 9, (i / 3) % 3, i % 3); end
      for (int t = 0; t < 9; t++) begin
        logic [7:0] b;
        b = q3[i].w[8*t +: 8];
        if (b != 8'h00) begin
          vectors++; if (int'(b[3:0]) != q3[i].ch) begin miscompares++; $display("FAIL mc_cross_channel[%0d.%0d] got %h want ch %0d", i, t, b, q3[i].ch); end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int flush; bit got;
    clear1();
    pulse_start(0);
    for (int i = 0; i < 7; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 8'(pixval(0, i));
      @(posedge clk); #1;
    end
    if1.in_valid = 1'b0;
    vectors++; if (if1.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", if1.out_valid); end
    #2 rst1 = 1'b1;
    #1;
    vectors++; if (if1.in_ready !== 1'b0 || if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_ctrl got %b%b want 00", if1.in_ready, if1.out_valid); end
    vectors++; if (if1.window !== 72'h0) begin miscompares++; $display("FAIL mid_async_window got %h want 0", if1.window); end
    vectors++; if ({if1.out_row, if1.out_col, if1.out_ch} !== 6'h0) begin miscompares++; $display("FAIL mid_async_tags got %h want 0", {if1.out_row, if1.out_col, if1.out_ch}); end
    @(posedge clk); #1;
    rst1 = 1'b0;
    clear1();
    pulse_start(0);
    send1(0, 0, 0);
    wait_done(0, flush, got);
    @(posedge clk); #1;
    vectors++; if (!got || flush != 5 || done_cnt1 != 1) begin miscompares++; $display("FAIL mid_frame_end got %0d/%0d/%0d want 1/5/1", got, flush, done_cnt1); end
    vectors++; if (q1.size() != 12) begin miscompares++; $display("FAIL mid_count got %0d want 12", q1.size()); end
    for (int i = 0; i < q1.size(); i++) begin
      logic [71:0] e;
      e = exp_win(0, 4, 3, 1, i / 4, i % 4, 0);
      vectors++; if (q1[i].w !== e || q1[i].r != i / 4 || q1[i].c != i % 4) begin miscompares++; $display("FAIL mid_win[%0d] got %h @%0d,%0d want %h", i, q1[i].w, q1[i].r, q1[i].c, e); end
    end
  endtask

  task automatic test_ignored_inputs();
    int flush; bit got;
    clear1();
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 8'hAA;
      @(posedge clk); #1;
      vectors++; if (if1.in_ready !== 1'b0 || if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid[%0d] got %b%b want 00", i, if1.in_ready, if1.out_valid); end
    end
    if1.in_valid = 1'b0;
    pulse_start(0);
    send1(0, 1, 1);
    wait_done(0, flush, got);
    if1.in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (!got || flush != 5 || done_cnt1 != 1) begin miscompares++; $display("FAIL ign_frame_end got %0d/%0d/%0d want 1/5/1", got, flush, done_cnt1); end
    vectors++; if (q1.size() != 12 || acc1 != 12) begin miscompares++; $display("FAIL ign_count got %0d/%0d want 12/12", q1.size(), acc1); end
    for (int i = 0; i < q1.size(); i++) begin
      logic [71:0] e;
      e = exp_win(0, 4, 3, 1, i / 4, i % 4, 0);
      vectors++; if (q1[i].w !== e || q1[i].r != i / 4 || q1[i].c != i % 4) begin miscompares++; $display("FAIL ign_win[%0d] got %h @%0d,%0d want %h", i, q1[i].w, q1[i].r, q1[i].c, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_multichannel();
    test_reset_midframe();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream stage of the image blur convolution.
- Accepts the raster-order, channel-interleaved 8-bit pixel stream (R,G,B per pixel, 3 bytes per pixel in default config) and emits, per input byte position, the 3x3 same-channel neighbourhood centred on that pixel.
- Out-of-image taps are zero-padded.
- Provides row/col/channel tags so the convolution stage can apply its kernel without any line storage of its own.

Parameters:
WIDTH, 350, image width in pixels
HEIGHT, 350, image height in pixels
CHANNELS, 3, interleaved bytes per pixel (1..4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse in IDLE begins a frame; ignored elsewhere
in_valid  input  1  in_data valid this cycle
in_data  input  8  pixel byte, order row, col, channel
in_ready  output  1  high only in STREAM; byte accepted when in_valid&&in_ready
out_valid  output  1  window/tags valid this cycle, one-cycle qualifier
window  output  72  taps; bits [8*(3*i+j)+:8] = row offset i-1, col offset j-1 (i=0 top, j=0 left)
out_row  output  clog2(HEIGHT)  centre row
out_col  output  clog2(WIDTH)  centre column
out_ch  output  2  centre channel
frame_done  output  1  one-cycle pulse after last window

Behaviour:
- Reset values: in_ready=0, out_valid=0, window=0, out_row/out_col/out_ch=0, frame_done=0, state=IDLE, all counters 0. Line-buffer contents need not be cleared; border masking makes stale data invisible.
- States and transitions:
  - IDLE: start moves to STREAM.
  - STREAM: in_ready=1. After accepting byte index N-1 (N=WIDTH*HEIGHT*CHANNELS), moves to FLUSH.
  - FLUSH: in_ready=0. Injects one zero byte per cycle internally. After LAG injected bytes, moves to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Storage:
  - Two line delays of WIDTH*CHANNELS bytes.
  - Three per-row shift chains of 2*CHANNELS+1 bytes, tapped at 0, CHANNELS and 2*CHANNELS.
  - Same-channel neighbours are thus CHANNELS positions apart.
- Latency:
  - LAG = WIDTH*CHANNELS + CHANNELS byte positions.
  - When the byte at stream index k (accepted or injected) has k >= LAG, the window centred at index k-LAG is registered.
  - out_valid=1 the following cycle; no cycle-count latency beyond that one register.
- Output count: exactly N out_valid pulses per frame, in raster/channel order.
- Gaps on in_valid stall the pipeline; no out_valid is produced on cycles with no accepted/injected byte.
- Zero padding: a tap is forced to 0 when centre row+offset is outside 0..HEIGHT-1 or centre col+offset is outside 0..WIDTH-1. This masking also hides left/right wrap contamination from the shift chains.
- Tags: out_row/out_col/out_ch come from a centre-position counter incremented per out_valid. Order is ch, then col, then row. Counters wrap to 0 at end of frame.
- start while not IDLE: ignored.
- in_valid outside STREAM: ignored, no state change.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The next frame after start must be bit-exact with a clean frame.
- Back-to-back frames: start may be pulsed in the cycle frame_done is high is not sampled; start accepted from the following IDLE cycle.

Test Plan:
1. WIDTH=4, HEIGHT=3, CHANNELS=1, bytes 1..12 streamed every cycle.
   - First out_valid comes the cycle after byte 6 is accepted.
   - Window (0,0) = [0,0,0; 0,1,2; 0,5,6].
   - Window (1,1) = [1,2,3; 5,6,7; 9,10,11].
   - Last window (2,3) = [7,8,0; 11,12,0; 0,0,0].
   - Exactly 12 out_valid pulses, 5 FLUSH cycles, one frame_done.
2. Same image with in_valid toggled 1,0,1,0.
   - Identical window sequence and tags to scenario 1.
   - No out_valid on stalled cycles.
3. WIDTH=3, HEIGHT=2, CHANNELS=3, byte = 16*pixel_index + ch.
   - Window (r0,c1,ch2) = [0,0,0; 0x02,0x12,0x22; 0x32,0x42,0x52].
   - No cross-channel taps anywhere; out_ch cycles 0,1,2.
4. Reset asserted mid-STREAM after 7 bytes, then start and full frame 1..12 (config 1).
   - Outputs drop to 0 asynchronously.
   - Second frame output matches scenario 1 exactly.
5. Default 350x350x3 frame of random bytes versus a software reference model.
   - 367500 windows match.
   - frame_done asserted once, 1053 flush cycles.
6. start pulsed during STREAM and in_valid asserted in IDLE: no effect on state, counters or outputs.
